// File: rtl/mt19937_seeder.sv
// mt19937_seeder: expands a 32-bit seed into the MT19937 state-word sequence
//   x[0] = seed, x[i] = INIT_MULT * (x[i-1] ^ (x[i-1] >> 30)) + i  (mod 2^32)
// and streams the words out one at a time over a valid/ready handshake.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   seed        seed value, sampled only when start is accepted
//   start       begin a seeding run (ignored while busy)
//   word_valid  word_data/word_index hold a valid state word
//   word_ready  consumer accepts the current word
//   word_data   state word x[word_index]
//   word_index  index of word_data, 0..NUM_WORDS-1
//   busy        run in progress
//   done        one-cycle pulse after the last word is accepted
//
// Build option MT19937_SEEDER_PIPE_MULT_EN: registers the multiplier output and
// inserts one CALC cycle (word_valid=0) after each non-last handshake.
module mt19937_seeder #(
    parameter int          NUM_WORDS = 624,
    parameter logic [31:0] INIT_MULT = 32'h6C078965
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  seed,
    input  logic                         start,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [31:0]                  word_data,
    output logic [$clog2(NUM_WORDS)-1:0] word_index,
    output logic                         busy,
    output logic                         done
);
    localparam int IW = $clog2(NUM_WORDS);

`ifdef MT19937_SEEDER_PIPE_MULT_EN
    typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;
    logic [31:0] prod_q;
`else
    typedef enum logic {IDLE, EMIT} state_t;
`endif

    state_t      state;
    logic [31:0] prod;
    logic        last;

    // Only the low 32 product bits matter; the index term is added afterwards.
    assign prod = INIT_MULT * (word_data ^ (word_data >> 30));
    assign last = word_index == IW'(NUM_WORDS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_index <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MT19937_SEEDER_PIPE_MULT_EN
            prod_q     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    word_data  <= seed;
                    word_index <= '0;
                    word_valid <= 1'b1;
                    busy       <= 1'b1;
                    state      <= EMIT;
                end
                EMIT: if (word_ready) begin
                    if (last) begin
                        done       <= 1'b1;
                        word_valid <= 1'b0;
                        busy       <= 1'b0;
                        word_index <= '0;
                        state      <= IDLE;
                    end else begin
                        word_index <= word_index + IW'(1);
`ifdef MT19937_SEEDER_PIPE_MULT_EN
                        prod_q     <= prod;
                        word_valid <= 1'b0;
                        state      <= CALC;
`else
                        word_data  <= prod + 32'(word_index) + 32'd1;
`endif
                    end
                end
`ifdef MT19937_SEEDER_PIPE_MULT_EN
                // word_index was already advanced on entry to CALC
                CALC: begin
                    word_data  <= prod_q + 32'(word_index);
                    word_valid <= 1'b1;
                    state      <= EMIT;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mt19937_seeder.sv
// tb_mt19937_seeder: directed self-checking bench for mt19937_seeder
module tb_mt19937_seeder;
    localparam int NW = 624;
`ifdef MT19937_SEEDER_PIPE_MULT_EN
    localparam int STR = 2;
`else
    localparam int STR = 1;
`endif

    logic        clk = 0, rst = 0, start = 0, word_ready = 0;
    logic [31:0] seed = 0;
    logic        word_valid, busy, done;
    logic [31:0] word_data;
    logic [9:0]  word_index;

    logic        s_start = 0, s_ready = 0;
    logic [31:0] s_seed = 0;
    logic        s_valid, s_busy, s_done;
    logic [31:0] s_data;
    logic [1:0]  s_index;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mt19937_seeder #(.NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .seed(seed), .start(start),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_index(word_index), .busy(busy), .done(done)
    );

    mt19937_seeder #(.NUM_WORDS(4)) dut_s (
        .clk(clk), .rst(rst), .seed(s_seed), .start(s_start),
        .word_valid(s_valid), .word_ready(s_ready), .word_data(s_data),
        .word_index(s_index), .busy(s_busy), .done(s_done)
    );

    function automatic logic [31:0] nxt(input logic [31:0] d, input int i);
        return 32'h6C078965 * (d ^ (d >> 30)) + 32'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1;
        #1;
        checks++;
        if ({word_valid, word_data, word_index, busy, done} !== 45'd0) begin
            failures++;
            $display("FAIL reset_async got v=%b d=%h i=%0d b=%b dn=%b want all 0", word_valid, word_data, word_index, busy, done);
        end
        step();
        step();
        rst = 0;
        step();
        checks++;
        if ({word_valid, word_data, word_index, busy, done} !== 45'd0) begin
            failures++;
            $display("FAIL reset_release got v=%b d=%h i=%0d b=%b dn=%b want all 0", word_valid, word_data, word_index, busy, done);
        end
        checks++;
        if ({s_valid, s_data, s_index, s_busy, s_done} !== 37'd0) begin
            failures++;
            $display("FAIL reset_small got v=%b d=%h i=%0d want all 0", s_valid, s_data, s_index);
        end
    endtask

    // Full run against the recurrence; checks index order, hold-while-stalled,
    // busy throughout, and the single done pulse after the last handshake.
    task automatic run_stream(input logic [31:0] s, input bit bp, input int poke_at,
                              output logic [31:0] w0, output logic [31:0] w1,
                              output logic [31:0] w2, output int done_cyc);
        logic [31:0] exp;
        int k, cyc, dones;
        w0 = 0; w1 = 0; w2 = 0;
        seed = s;
        start = 1;
        step();
        start = 0;
        seed = 32'hDEADBEEF;
        cyc = 1; k = 0; dones = 0; exp = s;
        while (k < NW && cyc < 6000) begin
            if (done) dones++;
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_run k=%0d got %b want 1", k, busy);
            end
            word_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (k == poke_at);
            if (word_valid) begin
                checks++;
                if (int'(word_index) != k || word_data !== exp) begin
                    failures++;
                    $display("FAIL word k=%0d got i=%0d d=%h want i=%0d d=%h", k, word_index, word_data, k, exp);
                end
                if (k == 0) w0 = word_data;
                if (k == 1) w1 = word_data;
                if (k == 2) w2 = word_data;
                if (word_ready) begin
                    k++;
                    if (k < NW) exp = nxt(exp, k);
                end
            end
            step();
            cyc++;
        end
        start = 0;
        word_ready = 1;
        checks++;
        if (k != NW) begin
            failures++;
            $display("FAIL handshakes got %0d want %0d", k, NW);
        end
        checks++;
        if ({done, word_valid, busy, word_index, word_data} !== {1'b1, 1'b0, 1'b0, 10'd0, exp}) begin
            failures++;
            $display("FAIL end_state got dn=%b v=%b b=%b i=%0d d=%h want dn=1 v=0 b=0 i=0 d=%h", done, word_valid, busy, word_index, word_data, exp);
        end
        done_cyc = cyc;
        step();
        checks++;
        if (done !== 1'b0 || dones != 0) begin
            failures++;
            $display("FAIL done_once got after=%b early=%0d want 0 0", done, dones);
        end
    endtask

    task automatic test_seed_5489();
        logic [31:0] w0, w1, w2;
        int dc;
        run_stream(32'd5489, 1'b0, -1, w0, w1, w2, dc);
        checks++;
        if (w0 !== 32'd5489 || w1 !== 32'h4D98EE96) begin
            failures++;
            $display("FAIL seed5489 got %h %h want 00001571 4d98ee96", w0, w1);
        end
        checks++;
        if (dc != (NW - 1) * STR + 2) begin
            failures++;
            $display("FAIL done_latency got %0d want %0d", dc, (NW - 1) * STR + 2);
        end
    endtask

    task automatic test_seed_zero();
        logic [31:0] w0, w1, w2;
        int dc;
        run_stream(32'd0, 1'b0, -1, w0, w1, w2, dc);
        checks++;
        if (w0 !== 32'h0 || w1 !== 32'h1 || w2 !== 32'h6C078967) begin
            failures++;
            $display("FAIL seed0 got %h %h %h want 00000000 00000001 6c078967", w0, w1, w2);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w0, w1, w2;
        int dc;
        run_stream(32'h12345678, 1'b1, -1, w0, w1, w2, dc);
    endtask

    task automatic test_start_ignored();
        logic [31:0] w0, w1, w2;
        int dc;
        run_stream(32'hCAFEF00D, 1'b0, 50, w0, w1, w2, dc);
    endtask

    task automatic test_abort();
        int g = 0;
        seed = 32'h0BADF00D;
        word_ready = 1;
        start = 1;
        step();
        start = 0;
        while (word_index !== 10'd100 && g < 1000) begin
            step();
            g++;
        end
        checks++;
        if (word_index !== 10'd100) begin
            failures++;
            $display("FAIL abort_reach got i=%0d want 100", word_index);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({word_valid, word_data, word_index, busy, done} !== 45'd0) begin
            failures++;
            $display("FAIL abort_zero got v=%b d=%h i=%0d b=%b dn=%b want all 0", word_valid, word_data, word_index, busy, done);
        end
        step();
        rst = 0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_nodone got dn=%b b=%b want 0 0", done, busy);
        end
        seed = 32'd7;
        start = 1;
        step();
        start = 0;
        checks++;
        if ({word_valid, busy, word_index, word_data} !== {1'b1, 1'b1, 10'd0, 32'd7}) begin
            failures++;
            $display("FAIL restart_w0 got v=%b b=%b i=%0d d=%h want 1 1 0 00000007", word_valid, busy, word_index, word_data);
        end
        repeat (STR) step();
        checks++;
        if ({word_valid, word_index, word_data} !== {1'b1, 10'd1, 32'hF434C1C4}) begin
            failures++;
            $display("FAIL restart_w1 got v=%b i=%0d d=%h want 1 1 f434c1c4", word_valid, word_index, word_data);
        end
        rst = 1;
        #2 rst = 0;
        word_ready = 0;
    endtask

    // NUM_WORDS=4 with start held: words, done, then the next run immediately.
    task automatic test_back_to_back();
        logic [31:0] ws [4];
        int p, pos, j;
        ws[0] = 32'd5489;
        for (int i = 1; i < 4; i++) ws[i] = nxt(ws[i-1], i);
        p = 3 * STR + 2;
        s_seed = 32'd5489;
        s_ready = 1;
        s_start = 1;
        for (int c = 1; c <= 2 * p + 1; c++) begin
            step();
            pos = (c - 1) % p;
            j = pos / STR;
            checks++;
            if (pos % STR == 0 && j < 4) begin
                if ({s_valid, s_done, s_busy} !== 3'b101 || int'(s_index) != j || s_data !== ws[j]) begin
                    failures++;
                    $display("FAIL b2b_word c=%0d got v=%b dn=%b i=%0d d=%h want v=1 dn=0 i=%0d d=%h", c, s_valid, s_done, s_index, s_data, j, ws[j]);
                end
            end else if (pos == 3 * STR + 1) begin
                if ({s_valid, s_done, s_busy} !== 3'b010 || s_index !== 2'd0 || s_data !== ws[3]) begin
                    failures++;
                    $display("FAIL b2b_done c=%0d got v=%b dn=%b b=%b i=%0d d=%h want v=0 dn=1 b=0 i=0 d=%h", c, s_valid, s_done, s_busy, s_index, s_data, ws[3]);
                end
            end else begin
                if ({s_valid, s_done, s_busy} !== 3'b001 || int'(s_index) != (pos + 1) / 2) begin
                    failures++;
                    $display("FAIL b2b_calc c=%0d got v=%b dn=%b b=%b i=%0d want v=0 dn=0 b=1 i=%0d", c, s_valid, s_done, s_busy, s_index, (pos + 1) / 2);
                end
            end
        end
        s_start = 0;
        checks++;
        if (ws[1] !== 32'h4D98EE96) begin
            failures++;
            $display("FAIL b2b_model got %h want 4d98ee96", ws[1]);
        end
    endtask

    initial begin
        test_reset();
        test_seed_5489();
        test_seed_zero();
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
